writeback_arbiter: RTL and testbench

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

---
 rtl/writeback_arbiter.sv | 99 +++++++++
 tb/tb_writeback_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges ALU and load results into one register-file write port.
// Latency: a source transfer in cycle N appears on rf_we/rf_waddr/rf_wdata in cycle N+1.
// Backpressure: only the granted source sees ready. Load beats ALU unless the ALU has lost STARVE_LIMIT cycles in a row.
//
// Ports:
//   clk, rst                        - clock, synchronous active-high reset
//   alu_valid/alu_ready/alu_rd/alu_data - ALU result source
//   mem_valid/mem_ready/mem_rd/mem_data - load result source
//   rf_we/rf_waddr/rf_wdata         - registered register-file write port
//   byp_rs{1,2}_addr/_hit/_data     - combinational forwarding of the current write
//                                     (present only when WB_BYPASS_EN is defined)
//
// Optional feature macro: WB_BYPASS_EN (forwarding ports and logic).
module writeback_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,

    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_data,

`ifdef WB_BYPASS_EN
    input  logic [4:0]  byp_rs1_addr,
    input  logic [4:0]  byp_rs2_addr,
    output logic        byp_rs1_hit,
    output logic        byp_rs2_hit,
    output logic [31:0] byp_rs1_data,
    output logic [31:0] byp_rs2_data,
`endif

    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    // Consecutive cycles the ALU was offering but lost to a load.
    logic [3:0]  starve_cnt;
    logic        force_alu;
    logic        xfer;
    logic [4:0]  sel_rd;
    logic [31:0] sel_data;

    assign force_alu = (starve_cnt == LIMIT);

    // Readies are held low during reset so nothing is consumed and then dropped.
    assign mem_ready = !rst && mem_valid && !force_alu;
    assign alu_ready = !rst && alu_valid && (!mem_valid || force_alu);

    assign xfer     = alu_ready || mem_ready;
    assign sel_rd   = mem_ready ? mem_rd   : alu_rd;
    assign sel_data = mem_ready ? mem_data : alu_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= 4'd0;
        end else if (alu_valid && mem_valid && mem_ready) begin
            if (starve_cnt != LIMIT) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end else if (alu_ready || !alu_valid) begin
            starve_cnt <= 4'd0;
        end
    end

    // Writes to x0 are consumed but never reach the register file; address
    // and data hold their last values whenever no write is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= 5'd0;
            rf_wdata <= 32'd0;
        end else if (xfer && (sel_rd != 5'd0)) begin
            rf_we    <= 1'b1;
            rf_waddr <= sel_rd;
            rf_wdata <= sel_data;
        end else begin
            rf_we    <= 1'b0;
        end
    end

`ifdef WB_BYPASS_EN
    // Forward the write currently on the port to the operand read stage.
    assign byp_rs1_hit  = rf_we && (byp_rs1_addr == rf_waddr) && (byp_rs1_addr != 5'd0);
    assign byp_rs2_hit  = rf_we && (byp_rs2_addr == rf_waddr) && (byp_rs2_addr != 5'd0);
    assign byp_rs1_data = byp_rs1_hit ? rf_wdata : 32'd0;
    assign byp_rs2_data = byp_rs2_hit ? rf_wdata : 32'd0;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
module tb_writeback_arbiter;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
`ifdef WB_BYPASS_EN
    logic [4:0]  byp_rs1_addr;
    logic [4:0]  byp_rs2_addr;
    logic        byp_rs1_hit;
    logic        byp_rs2_hit;
    logic [31:0] byp_rs1_data;
    logic [31:0] byp_rs2_data;
`endif

    writeback_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
`ifdef WB_BYPASS_EN
        .byp_rs1_addr (byp_rs1_addr),
        .byp_rs2_addr (byp_rs2_addr),
        .byp_rs1_hit  (byp_rs1_hit),
        .byp_rs2_hit  (byp_rs2_hit),
        .byp_rs1_data (byp_rs1_data),
        .byp_rs2_data (byp_rs2_data),
`endif
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] md;
        logic        e_ar;
        logic        e_mr;
        logic        e_we;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
    } vec_t;

    localparam int NV = 30;
    vec_t vecs [NV];

    int checks   = 0;
    int failures = 0;

    function automatic vec_t mk(logic r, logic av, logic [4:0] ard, logic [31:0] ad,
                                logic mv, logic [4:0] mrd, logic [31:0] md,
                                logic ar, logic mr, logic we, logic [4:0] wa, logic [31:0] wd);
        vec_t v;
        v.rst = r;  v.av = av; v.ard = ard; v.ad = ad;
        v.mv = mv;  v.mrd = mrd; v.md = md;
        v.e_ar = ar; v.e_mr = mr; v.e_we = we; v.e_wa = wa; v.e_wd = wd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    initial begin
        int grant_cycle;

        rst = 1'b1;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
`ifdef WB_BYPASS_EN
        byp_rs1_addr = '0; byp_rs2_addr = '0;
`endif

        // Reset with both sources offering.
        vecs[0]  = mk(1, 1, 3, 32'h1,        1, 7,  32'h2,        0, 0, 0, 0,  32'h0);
        vecs[1]  = mk(1, 1, 3, 32'h1,        1, 7,  32'h2,        0, 0, 0, 0,  32'h0);
        // Single ALU write, idle hold, x0 drop.
        vecs[2]  = mk(0, 1, 5, 32'h12345678, 0, 0,  32'h0,        1, 0, 1, 5,  32'h12345678);
        vecs[3]  = mk(0, 0, 0, 32'h0,        0, 0,  32'h0,        0, 0, 0, 5,  32'h12345678);
        vecs[4]  = mk(0, 0, 0, 32'h0,        1, 0,  32'hFFFFFFFF, 0, 1, 0, 5,  32'h12345678);
        // Contention: four loads, then forced ALU grant, then loads resume.
        vecs[5]  = mk(0, 1, 3, 32'hAAAA0003, 1, 7,  32'h70000001, 0, 1, 1, 7,  32'h70000001);
        vecs[6]  = mk(0, 1, 3, 32'hAAAA0003, 1, 7,  32'h70000002, 0, 1, 1, 7,  32'h70000002);
        vecs[7]  = mk(0, 1, 3, 32'hAAAA0003, 1, 7,  32'h70000003, 0, 1, 1, 7,  32'h70000003);
        vecs[8]  = mk(0, 1, 3, 32'hAAAA0003, 1, 7,  32'h70000004, 0, 1, 1, 7,  32'h70000004);
        vecs[9]  = mk(0, 1, 3, 32'hAAAA0003, 1, 7,  32'h70000005, 1, 0, 1, 3,  32'hAAAA0003);
        vecs[10] = mk(0, 1, 3, 32'hAAAA0004, 1, 7,  32'h70000005, 0, 1, 1, 7,  32'h70000005);
        // ALU drops valid: counter clears, so next force needs four fresh losses.
        vecs[11] = mk(0, 0, 0, 32'h0,        1, 7,  32'h70000006, 0, 1, 1, 7,  32'h70000006);
        vecs[12] = mk(0, 1, 3, 32'hAAAA0005, 1, 7,  32'h70000007, 0, 1, 1, 7,  32'h70000007);
        vecs[13] = mk(0, 1, 3, 32'hAAAA0005, 1, 7,  32'h70000008, 0, 1, 1, 7,  32'h70000008);
        vecs[14] = mk(0, 1, 3, 32'hAAAA0005, 1, 7,  32'h70000009, 0, 1, 1, 7,  32'h70000009);
        vecs[15] = mk(0, 1, 3, 32'hAAAA0005, 1, 7,  32'h7000000A, 0, 1, 1, 7,  32'h7000000A);
        vecs[16] = mk(0, 1, 3, 32'hAAAA0005, 1, 7,  32'h7000000B, 1, 0, 1, 3,  32'hAAAA0005);
        // ALU write to x0, then load to x31.
        vecs[17] = mk(0, 1, 0, 32'hDEADBEEF, 0, 0,  32'h0,        1, 0, 0, 3,  32'hAAAA0005);
        vecs[18] = mk(0, 0, 0, 32'h0,        1, 31, 32'h80000000, 0, 1, 1, 31, 32'h80000000);
        // Build starve count to 3, reset with a write pending, then contention restarts at 0.
        vecs[19] = mk(0, 1, 3, 32'h33,       1, 7,  32'h71,       0, 1, 1, 7,  32'h71);
        vecs[20] = mk(0, 1, 3, 32'h33,       1, 7,  32'h72,       0, 1, 1, 7,  32'h72);
        vecs[21] = mk(0, 1, 3, 32'h33,       1, 7,  32'h73,       0, 1, 1, 7,  32'h73);
        vecs[22] = mk(1, 1, 3, 32'h33,       1, 7,  32'h74,       0, 0, 0, 0,  32'h0);
        vecs[23] = mk(0, 1, 3, 32'h33,       1, 7,  32'h74,       0, 1, 1, 7,  32'h74);
        vecs[24] = mk(0, 1, 3, 32'h33,       1, 7,  32'h75,       0, 1, 1, 7,  32'h75);
        vecs[25] = mk(0, 1, 3, 32'h33,       1, 7,  32'h76,       0, 1, 1, 7,  32'h76);
        vecs[26] = mk(0, 1, 3, 32'h33,       1, 7,  32'h77,       0, 1, 1, 7,  32'h77);
        vecs[27] = mk(0, 1, 3, 32'h33,       1, 7,  32'h78,       1, 0, 1, 3,  32'h33);
        vecs[28] = mk(0, 0, 0, 32'h0,        1, 7,  32'h78,       0, 1, 1, 7,  32'h78);
        vecs[29] = mk(0, 0, 0, 32'h0,        0, 0,  32'h0,        0, 0, 0, 7,  32'h78);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst       = vecs[i].rst;
            alu_valid = vecs[i].av;
            alu_rd    = vecs[i].ard;
            alu_data  = vecs[i].ad;
            mem_valid = vecs[i].mv;
            mem_rd    = vecs[i].mrd;
            mem_data  = vecs[i].md;
            #1;
            check($sformatf("v%0d alu_ready", i), 32'(alu_ready), 32'(vecs[i].e_ar));
            check($sformatf("v%0d mem_ready", i), 32'(mem_ready), 32'(vecs[i].e_mr));
            @(posedge clk);
            #1;
            check($sformatf("v%0d rf_we", i),    32'(rf_we),    32'(vecs[i].e_we));
            check($sformatf("v%0d rf_waddr", i), 32'(rf_waddr), 32'(vecs[i].e_wa));
            check($sformatf("v%0d rf_wdata", i), rf_wdata,      vecs[i].e_wd);
        end

        // Sustained contention from a cleared counter: ALU must win on cycle 5.
        grant_cycle = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h44;
            mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h90 + 32'(c);
            #1;
            if (alu_ready && grant_cycle == 0) grant_cycle = c;
            @(posedge clk);
            #1;
            if (grant_cycle != 0) break;
        end
        check("starve_grant_cycle", 32'(grant_cycle), 32'd5);
        check("starve_grant_waddr", 32'(rf_waddr), 32'd4);
        check("starve_grant_wdata", rf_wdata, 32'h44);

`ifdef WB_BYPASS_EN
        @(negedge clk);
        alu_valid = 1'b0;
        mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'hA5A50001;
        byp_rs1_addr = 5'd9; byp_rs2_addr = 5'd0;
        @(posedge clk);
        #1;
        check("byp_rs1_hit",  32'(byp_rs1_hit), 32'd1);
        check("byp_rs1_data", byp_rs1_data,     32'hA5A50001);
        check("byp_rs2_hit",  32'(byp_rs2_hit), 32'd0);
        check("byp_rs2_data", byp_rs2_data,     32'h0);
        byp_rs1_addr = 5'd10;
        #1;
        check("byp_rs1_miss", 32'(byp_rs1_hit), 32'd0);
`endif

        @(negedge clk);
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        @(posedge clk);
        #1;
        check("final_idle_we", 32'(rf_we), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
